pe_dot_accel: RTL and testbench

//  Parametrised successor of the single-MAC PE accelerator: a dot-product engine behind the same

---
 rtl/pe_dot_accel_if.sv | 21 ++
 rtl/pe_dot_accel.sv | 204 ++++++++++++++++++++
 tb/tb_pe_dot_accel.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pe_dot_accel_if.sv
// SRAM-like slave bus of the dot-product accelerator.
// Signal names follow the axi2mem bridge memory port.
interface pe_dot_accel_if #(
    parameter int ADDR_WIDTH = 2
);
    logic                  req_i;
    logic [3:0]            wen_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [31:0]           data_i;
    logic [31:0]           data_o;

    modport master (
        output req_i, wen_i, addr_i, data_i,
        input  data_o
    );

    modport slave (
        input  req_i, wen_i, addr_i, data_i,
        output data_o
    );
endinterface

// File: rtl/pe_dot_accel.sv
// Dot-product engine: operand FIFO, IDLE/RUN sequencer and
// a signed, optionally saturating MAC accumulator.
module pe_dot_accel #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int DEPTH      = 16
) (
    input logic           clk_i,
    input logic           rst_ni,
    pe_dot_accel_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PR = 2 * DATA_W + 2;

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] fa_q [DEPTH];
    logic [DATA_W-1:0] fa_d [DEPTH];
    logic [DATA_W-1:0] fb_q [DEPTH];
    logic [DATA_W-1:0] fb_d [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     run_len_q, run_len_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              mode_q, mode_d;
    logic              sat_q, sat_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              perr_q, perr_d;

    logic wr, rd, push_wr, ctrl_wr, res_rd;
    logic full, empty, push_ok, pop;
    logic start, clr_acc, flush, clr_err;

    assign wr      = bus.req_i & bus.wen_i[0];
    assign rd      = bus.req_i & ~|bus.wen_i;
    assign push_wr = wr & (bus.addr_i == ADDR_WIDTH'(0));
    assign ctrl_wr = wr & (bus.addr_i == ADDR_WIDTH'(1));
    assign res_rd  = rd & (bus.addr_i == ADDR_WIDTH'(2));
    assign start   = ctrl_wr & bus.data_i[0];
    assign clr_acc = ctrl_wr & bus.data_i[2];
    assign flush   = ctrl_wr & bus.data_i[3];
    assign clr_err = ctrl_wr & bus.data_i[5];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_wr & ~full;

    // MAC datapath: product widened to PR bits, sum at ACC_W+1
    logic [DATA_W-1:0]      a_h, b_h;
    logic signed [PR-1:0]   a_x, b_x, prod;
    logic [ACC_W:0]         sum;
    logic                   mac_ovf;
    logic [ACC_W-1:0]       mac_res;

    always_comb begin
        a_h  = fa_q[rptr_q];
        b_h  = fb_q[rptr_q];
        a_x  = mode_q ? {{(DATA_W + 2){a_h[DATA_W-1]}}, a_h}
                      : {{(DATA_W + 2){1'b0}}, a_h};
        b_x  = {{(DATA_W + 2){b_h[DATA_W-1]}}, b_h};
        prod = a_x * b_x;
        sum  = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W - 2 * DATA_W){prod[2*DATA_W]}}, prod[2*DATA_W:0]};
        mac_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        mac_res = sum[ACC_W-1:0];
        if (mac_ovf && sat_q) begin
            mac_res = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                 : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        run_len_d = run_len_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        sat_d     = sat_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        perr_d    = perr_q;
        pop       = 1'b0;

        if (res_rd) done_d = 1'b0;
        if (clr_err) begin
            ovf_d  = 1'b0;
            perr_d = 1'b0;
        end
        if (push_wr && full) perr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (ctrl_wr) begin
                    mode_d = bus.data_i[1];
                    sat_d  = bus.data_i[4];
                end
                if (clr_acc) acc_d = '0;
                if (start) begin
                    // a flush in the same write leaves nothing to run
                    run_len_d = flush ? '0 : count_q;
                    if (flush || empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    pop       = 1'b1;
                    acc_d     = mac_res;
                    run_len_d = run_len_q - CW'(1);
                    if (mac_ovf) ovf_d = 1'b1;
                    if (run_len_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_ok) begin
            fa_d[wptr_q] = bus.data_i[DATA_W-1:0];
            fb_d[wptr_q] = bus.data_i[DATA_W+15:16];
            wptr_d       = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                fa_q[i] <= '0;
                fb_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            run_len_q <= '0;
            acc_q     <= '0;
            mode_q    <= 1'b0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fa_q      <= fa_d;
            fb_q      <= fb_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            run_len_q <= run_len_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            sat_q     <= sat_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
        end
    end

    logic [31:0] rdata;
    logic        busy;

    assign busy = (state_q == RUN);

    always_comb begin
        rdata = '0;
        case (bus.addr_i)
            ADDR_WIDTH'(0): rdata = {24'h0, 8'(count_q)};
            ADDR_WIDTH'(1): rdata = {8'h0, 8'(count_q), 3'b0,
                                     empty, full, perr_q, ovf_q, done_q,
                                     3'b0, sat_q, 2'b0, mode_q, busy};
            ADDR_WIDTH'(2): rdata = 32'(signed'(acc_q));
            ADDR_WIDTH'(3): rdata = {8'(DEPTH), 8'(DATA_W),
                                     8'(ACC_W), 8'h01};
            default:        rdata = '0;
        endcase
    end

    assign bus.data_o = rdata;

    logic unused_bits;
    assign unused_bits = ^{bus.data_i, prod};
endmodule

// File: tb/tb_pe_dot_accel.sv
// Directed self-checking bench for pe_dot_accel.
// Bus driven at falling edges, outputs sampled 1ns later.
module tb_pe_dot_accel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pe_dot_accel_if #(.ADDR_WIDTH(2)) bus ();

    pe_dot_accel #(
        .ADDR_WIDTH(2),
        .DATA_W    (8),
        .ACC_W     (24),
        .DEPTH     (16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.req_i  = 1'b1;
        bus.wen_i  = 4'hF;
        bus.addr_i = a;
        bus.data_i = d;
        @(negedge clk);
        bus.req_i  = 1'b0;
        bus.wen_i  = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        bus.req_i  = 1'b1;
        bus.wen_i  = 4'h0;
        bus.addr_i = a;
        #1;
        chk(tag, bus.data_o, exp);
        @(negedge clk);
        bus.req_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic batch(input logic [31:0] ctrl);
        for (int i = 0; i < 16; i++) wr(2'd0, 32'h007F_007F);
        wr(2'd1, ctrl);
        idle(17);
    endtask

    initial begin
        bus.req_i  = 1'b0;
        bus.wen_i  = 4'h0;
        bus.addr_i = 2'd0;
        bus.data_i = 32'h0;
        idle(2);
        rst_n = 1'b1;

        rd_chk("rst_ctrl", 2'd1, 32'h0000_1000);
        rd_chk("rst_res",  2'd2, 32'h0000_0000);
        rd_chk("rst_push", 2'd0, 32'h0000_0000);
        rd_chk("info",     2'd3, 32'h1008_1801);

        wr(2'd1, 32'h1);
        rd_chk("zero_run", 2'd1, 32'h0000_1100);
        rd_chk("zero_res", 2'd2, 32'h0000_0000);
        rd_chk("zero_clr", 2'd1, 32'h0000_1000);

        // 3*-2 + 5*4 + -1*7 = 7
        wr(2'd0, 32'h00FE_0003);
        wr(2'd0, 32'h0004_0005);
        wr(2'd0, 32'h0007_00FF);
        wr(2'd1, 32'h7);
        rd_chk("run_c3",   2'd1, 32'h0003_0003);
        rd_chk("run_c2",   2'd1, 32'h0002_0003);
        rd_chk("run_c1",   2'd1, 32'h0001_0003);
        rd_chk("run_done", 2'd1, 32'h0000_1102);
        rd_chk("run_res",  2'd2, 32'h0000_0007);
        rd_chk("done_clr", 2'd1, 32'h0000_1002);

        // unsigned a=255, b=-1
        wr(2'd1, 32'h4);
        rd_chk("uns_clr",  2'd1, 32'h0000_1000);
        wr(2'd0, 32'h00FF_00FF);
        wr(2'd1, 32'h1);
        idle(1);
        rd_chk("uns_done", 2'd1, 32'h0000_1100);
        rd_chk("uns_res",  2'd2, 32'hFFFF_FF01);
        rd_chk("uns_dclr", 2'd1, 32'h0000_1000);

        for (int i = 0; i < 17; i++) wr(2'd0, 32'h0001_0001);
        rd_chk("full_cnt", 2'd0, 32'h0000_0010);
        rd_chk("full_err", 2'd1, 32'h0010_0C00);
        wr(2'd1, 32'h20);
        rd_chk("err_clr",  2'd1, 32'h0010_0800);
        wr(2'd1, 32'h8);
        rd_chk("flush_id", 2'd1, 32'h0000_1000);

        // 16129 per pair, 258064 per batch
        wr(2'd1, 32'h4);
        for (int r = 0; r < 32; r++) batch(32'h13);
        rd_chk("sat32_st", 2'd1, 32'h0000_1112);
        rd_chk("sat32_rs", 2'd2, 32'h007E_0200);
        batch(32'h13);
        rd_chk("sat_st",   2'd1, 32'h0000_1312);
        rd_chk("sat_res",  2'd2, 32'h007F_FFFF);

        wr(2'd1, 32'h26);
        rd_chk("wrap_clr", 2'd1, 32'h0000_1002);
        for (int r = 0; r < 33; r++) batch(32'h03);
        rd_chk("wrap_st",  2'd1, 32'h0000_1302);
        rd_chk("wrap_res", 2'd2, 32'hFF81_F210);

        // pairs (i+1, i+2); first three sum to 20
        wr(2'd1, 32'h26);
        for (int i = 0; i < 8; i++) begin
            wr(2'd0, {8'h0, 8'(i + 2), 8'h0, 8'(i + 1)});
        end
        wr(2'd1, 32'h3);
        idle(3);
        wr(2'd1, 32'hA);
        rd_chk("abort_st", 2'd1, 32'h0000_1002);
        rd_chk("abort_rs", 2'd2, 32'h0000_0014);

        for (int i = 0; i < 4; i++) wr(2'd0, 32'h0001_0001);
        wr(2'd1, 32'h3);
        idle(2);
        rst_n = 1'b0;
        bus.addr_i = 2'd1;
        #1;
        chk("mrst_ctrl", bus.data_o, 32'h0000_1000);
        bus.addr_i = 2'd2;
        #1;
        chk("mrst_res", bus.data_o, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd_chk("mrst_post", 2'd1, 32'h0000_1000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
